ddr3_cmd_timer: RTL and testbench
=================================

DDR3_CMD_TIMER -- requirements
Module: ddr3_cmd_timer

Interface
REQ-001 SHALL have parameter DDR_FREQ_MHZ, default 100, controller clock frequency; TCK = 1000/DDR_FREQ_MHZ ns.
REQ-002 SHALL have parameter TRCD, default 15, ACTIVATE-to-READ/WRITE time in ns.
REQ-003 SHALL have parameter TRP, default 15, PRECHARGE period in ns.
REQ-004 SHALL have parameter TRFC, default 110, REFRESH cycle time in ns.
REQ-005 SHALL have parameter TWR, default 15, write-recovery time in ns.
REQ-006 SHALL have parameter TMOD_CYCLES, default 12, MODE-register-set delay in clocks.
REQ-007 SHALL have parameter TZQ_CYCLES, default 512, ZQCL delay in clocks.
REQ-008 SHALL have parameter CL_CYCLES, default 6, and parameter CWL_CYCLES, default 6 (DLL=off).
REQ-009 clock  in  1  shared controller clock; reset  in  1  reset, synchronous, active-high.
REQ-010 cmd_valid_i  in  1  command request from the scheduling FSM.
REQ-011 cmd_ready_o  out  1  command accepted this cycle when high with cmd_valid_i.
REQ-012 cmd_i  in  3  {RAS#,CAS#,WE#}: NOOP=111, ZQCL=110, READ=101, WRIT=100, ACTV=011, PREC=010, REFR=001, MODE=000.
REQ-013 bank_i  in  3  bank address; addr_i  in  13  row/column/mode address, A10 = auto/all-precharge.
REQ-014 rfc_o  out  1  one-cycle pulse on REFRESH completion.
REQ-015 ddr_cs_n_o, ddr_ras_n_o, ddr_cas_n_o, ddr_we_n_o  out  1 each  registered DDR3 command pins.
REQ-016 ddr_ba_o  out  3  and  ddr_a_o  out  13  registered DDR3 bank/address pins.

Function
REQ-017 Command delay D (clocks), from ceil(ns/TCK): ACTV=ceil(TRCD), PREC=ceil(TRP), REFR=ceil(TRFC), WRIT=CWL_CYCLES+4+ceil(TWR), READ=CL_CYCLES+4, MODE=TMOD_CYCLES, ZQCL=TZQ_CYCLES; all D >= 1. At defaults: 2, 2, 11, 12, 10, 12, 512.
REQ-018 State machine: IDLE (timer==0) and BUSY (timer>0); cmd_ready_o SHALL equal (state==IDLE) combinationally.
REQ-019 Accept = cmd_valid_i && cmd_ready_o; a non-NOOP accept in cycle N SHALL load timer with D-1 and latch the command type.
REQ-020 An accepted command SHALL appear on the pins in cycle N+1 for exactly one cycle, with cs_n=0 and ba/a = bank_i/addr_i; all other cycles SHALL drive cs_n=0, ras/cas/we=1 (NOOP), with ba/a holding their last values.
REQ-021 Consequently, the next command appears no earlier than D cycles after the previous one; D=1 permits back-to-back issue.
REQ-022 Accepting NOOP SHALL NOT load the timer or change the pins.
REQ-023 In BUSY, timer SHALL decrement by 1 per cycle; returning to IDLE when it reaches 0; cmd_valid_i is ignored.
REQ-024 rfc_o SHALL pulse high in the single cycle the timer transitions 1->0 (or, for D=1, the cycle after accept) when the latched command is REFR; otherwise low.
REQ-025 Timer width SHALL be $clog2 of the maximum D plus 1; no wrap-around is permitted.
REQ-026 cmd_i/bank_i/addr_i SHALL be sampled only on accept; changes while BUSY have no effect.

Reset
REQ-027 Reset SHALL force: state=IDLE, timer=0, latched command=NOOP, rfc_o=0, cs_n=0, ras_n=cas_n=we_n=1, ba=0, a=0.
REQ-028 Reset asserted mid-BUSY SHALL abort the countdown, suppress rfc_o, and present NOOP on the next cycle.
REQ-029 cmd_ready_o SHALL be 0 while reset is high.

Structure
REQ-030 Command encodings and the ns-to-cycles function SHALL live in shared package ddr3_pkg, used also by ddr3_fsm.
REQ-031 No sub-module is required; the delay lookup SHALL be a constant case table inside ddr3_cmd_timer.

Verification
REQ-032 ACTV (bank 2, row 0x123) accepted in cycle 0 -> pins RAS#=0 CAS#=1 WE#=1, ba=2, a=0x123 in cycle 1 only; ready low in cycle 1, high in cycle 2.
REQ-033 REFR accepted in cycle 0 -> ready low in cycles 1-10; rfc_o high in cycle 10 only; READ accepted in cycle 11 appears on the pins in cycle 12.
REQ-034 WRIT, then READ held valid -> READ issued on the pins exactly 12 cycles after WRIT.
REQ-035 ZQCL accepted in cycle 0, reset pulsed in cycle 100 -> NOOP on the pins and ready high in cycle 102; rfc_o never asserted.
REQ-036 NOOP valid for 5 cycles, then PREC with A10=1 -> timer untouched during NOOPs; PREC on the pins with a[10]=1; ready low for 1 cycle.

Source files
------------

// File: rtl/ddr3_pkg.sv
// ddr3_pkg -- shared DDR3 controller definitions.
//
// Purpose: command encodings ({RAS#,CAS#,WE#}), the command-timer state
// type, and helpers that turn nanosecond timings into controller clocks.
// Used by ddr3_cmd_timer and by the scheduling FSM (ddr3_fsm).
//
// Ports: none (package).

package ddr3_pkg;

    // Encoding is the raw {RAS#,CAS#,WE#} pin pattern, so a command value
    // can be driven straight onto the pins.
    typedef enum logic [2:0] {
        CMD_MODE = 3'b000,
        CMD_REFR = 3'b001,
        CMD_PREC = 3'b010,
        CMD_ACTV = 3'b011,
        CMD_WRIT = 3'b100,
        CMD_READ = 3'b101,
        CMD_ZQCL = 3'b110,
        CMD_NOOP = 3'b111
    } cmd_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } timer_state_e;

    // ceil(ns / TCK) with TCK = 1000/freq_mhz ns, i.e. ceil(ns*freq/1000).
    // Never returns less than one clock.
    function automatic int unsigned ns_to_cycles(input int unsigned ns,
                                                 input int unsigned freq_mhz);
        int unsigned cyc;
        cyc = (ns * freq_mhz + 999) / 1000;
        return (cyc == 0) ? 1 : cyc;
    endfunction

    // Clamp a clock-count delay so a command always occupies at least one cycle.
    function automatic int unsigned at_least_one(input int unsigned cyc);
        return (cyc == 0) ? 1 : cyc;
    endfunction

    function automatic int unsigned max_u(input int unsigned a,
                                          input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/ddr3_cmd_timer.sv
// ddr3_cmd_timer -- DDR3 command issue gate with per-command spacing timer.
//
// Purpose: accepts one command at a time from the scheduling FSM, drives it
// onto registered DDR3 command pins for exactly one cycle, and then blocks
// further commands until that command's minimum delay D has elapsed.
// A REFRESH raises rfc_o for one cycle at the point its timer expires.
//
// Handshake: a command transfers in a cycle where cmd_valid_i and
// cmd_ready_o are both high. cmd_ready_o depends only on the timer state
// (and reset), never on cmd_valid_i. cmd_i/bank_i/addr_i are sampled only
// on a transfer. Accepting NOOP is a legal no-op transfer.
//
// Ports:
//   clock, reset        - clock and synchronous active-high reset
//   cmd_valid_i         - command request
//   cmd_ready_o         - timer idle, command can be accepted
//   cmd_i [2:0]         - {RAS#,CAS#,WE#} command code
//   bank_i [2:0]        - bank address
//   addr_i [12:0]       - row/column/mode address (A10 = auto/all precharge)
//   rfc_o               - one-cycle pulse on REFRESH completion
//   ddr_cs_n_o, ddr_ras_n_o, ddr_cas_n_o, ddr_we_n_o - command pins
//   ddr_ba_o [2:0], ddr_a_o [12:0]                   - bank/address pins
//   dbg_state_o         - timer state (1 = BUSY) for observation

module ddr3_cmd_timer
    import ddr3_pkg::*;
#(
    parameter int unsigned DDR_FREQ_MHZ = 100,
    parameter int unsigned TRCD         = 15,
    parameter int unsigned TRP          = 15,
    parameter int unsigned TRFC         = 110,
    parameter int unsigned TWR          = 15,
    parameter int unsigned TMOD_CYCLES  = 12,
    parameter int unsigned TZQ_CYCLES   = 512,
    parameter int unsigned CL_CYCLES    = 6,
    parameter int unsigned CWL_CYCLES   = 6
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic [2:0]  cmd_i,
    input  logic [2:0]  bank_i,
    input  logic [12:0] addr_i,
    output logic        rfc_o,
    output logic        ddr_cs_n_o,
    output logic        ddr_ras_n_o,
    output logic        ddr_cas_n_o,
    output logic        ddr_we_n_o,
    output logic [2:0]  ddr_ba_o,
    output logic [12:0] ddr_a_o,
    output logic        dbg_state_o
);

    // Per-command delays in clocks.
    localparam int unsigned D_ACTV = ns_to_cycles(TRCD, DDR_FREQ_MHZ);
    localparam int unsigned D_PREC = ns_to_cycles(TRP, DDR_FREQ_MHZ);
    localparam int unsigned D_REFR = ns_to_cycles(TRFC, DDR_FREQ_MHZ);
    localparam int unsigned D_WRIT = CWL_CYCLES + 4 + ns_to_cycles(TWR, DDR_FREQ_MHZ);
    localparam int unsigned D_READ = at_least_one(CL_CYCLES + 4);
    localparam int unsigned D_MODE = at_least_one(TMOD_CYCLES);
    localparam int unsigned D_ZQCL = at_least_one(TZQ_CYCLES);

    localparam int unsigned D_MAX = max_u(max_u(max_u(D_ACTV, D_PREC),
                                                max_u(D_REFR, D_WRIT)),
                                          max_u(max_u(D_READ, D_MODE), D_ZQCL));

    // One bit of headroom over the largest load value, so D-1 never wraps.
    localparam int unsigned TW = $clog2(D_MAX) + 1;

    timer_state_e  state_q;
    logic [TW-1:0] timer_q;
    cmd_e          cmd_q;
    logic          rfc_q;
    logic          cs_n_q;
    logic          ras_n_q;
    logic          cas_n_q;
    logic          we_n_q;
    logic [2:0]    ba_q;
    logic [12:0]   a_q;

    cmd_e          cmd_in;
    logic [TW-1:0] load_val;
    logic          accept;

    assign cmd_in      = cmd_e'(cmd_i);
    assign cmd_ready_o = (state_q == ST_IDLE) && !reset;
    assign accept      = cmd_valid_i && cmd_ready_o;

    // Constant delay table: value loaded into the timer is D-1.
    always_comb begin
        load_val = '0;
        case (cmd_in)
            CMD_ACTV: load_val = TW'(D_ACTV - 1);
            CMD_PREC: load_val = TW'(D_PREC - 1);
            CMD_REFR: load_val = TW'(D_REFR - 1);
            CMD_WRIT: load_val = TW'(D_WRIT - 1);
            CMD_READ: load_val = TW'(D_READ - 1);
            CMD_MODE: load_val = TW'(D_MODE - 1);
            CMD_ZQCL: load_val = TW'(D_ZQCL - 1);
            default:  load_val = '0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            timer_q <= '0;
            cmd_q   <= CMD_NOOP;
            rfc_q   <= 1'b0;
            cs_n_q  <= 1'b0;
            ras_n_q <= 1'b1;
            cas_n_q <= 1'b1;
            we_n_q  <= 1'b1;
            ba_q    <= '0;
            a_q     <= '0;
        end else begin
            // Pins fall back to NOOP every cycle unless a command is issued;
            // ba/a keep their last values.
            cs_n_q  <= 1'b0;
            ras_n_q <= 1'b1;
            cas_n_q <= 1'b1;
            we_n_q  <= 1'b1;
            rfc_q   <= 1'b0;

            case (state_q)
                ST_IDLE: begin
                    if (accept && (cmd_in != CMD_NOOP)) begin
                        timer_q <= load_val;
                        cmd_q   <= cmd_in;
                        ras_n_q <= cmd_i[2];
                        cas_n_q <= cmd_i[1];
                        we_n_q  <= cmd_i[0];
                        ba_q    <= bank_i;
                        a_q     <= addr_i;
                        state_q <= (load_val == '0) ? ST_IDLE : ST_BUSY;
                        // D=1: pulse in the cycle after accept.
                        // D=2: timer is 1 in that cycle and expires there.
                        rfc_q   <= (cmd_in == CMD_REFR) && (load_val <= TW'(1));
                    end
                end
                ST_BUSY: begin
                    timer_q <= timer_q - TW'(1);
                    if (timer_q == TW'(1)) begin
                        state_q <= ST_IDLE;
                    end
                    // Register the pulse one cycle early so it coincides
                    // with the cycle where the timer goes 1 -> 0.
                    rfc_q <= (cmd_q == CMD_REFR) && (timer_q == TW'(2));
                end
                default: begin
                    state_q <= ST_IDLE;
                    timer_q <= '0;
                end
            endcase
        end
    end

    assign rfc_o       = rfc_q;
    assign ddr_cs_n_o  = cs_n_q;
    assign ddr_ras_n_o = ras_n_q;
    assign ddr_cas_n_o = cas_n_q;
    assign ddr_we_n_o  = we_n_q;
    assign ddr_ba_o    = ba_q;
    assign ddr_a_o     = a_q;
    assign dbg_state_o = (state_q == ST_BUSY);

endmodule

// File: tb/tb_ddr3_cmd_timer.sv
// tb_ddr3_cmd_timer -- directed bench for ddr3_cmd_timer at default parameters.
// Expected delays at 100 MHz: ACTV 2, PREC 2, REFR 11, WRIT 12, READ 10,
// MODE 12, ZQCL 512 clocks.

module tb_ddr3_cmd_timer;

    logic        clock = 1'b0;
    logic        reset;
    logic        cmd_valid_i;
    logic        cmd_ready_o;
    logic [2:0]  cmd_i;
    logic [2:0]  bank_i;
    logic [12:0] addr_i;
    logic        rfc_o;
    logic        ddr_cs_n_o;
    logic        ddr_ras_n_o;
    logic        ddr_cas_n_o;
    logic        ddr_we_n_o;
    logic [2:0]  ddr_ba_o;
    logic [12:0] ddr_a_o;
    logic        dbg_state_o;

    int n_cmp = 0;
    int n_err = 0;

    localparam logic [2:0] C_NOOP = 3'b111;
    localparam logic [2:0] C_ZQCL = 3'b110;
    localparam logic [2:0] C_READ = 3'b101;
    localparam logic [2:0] C_WRIT = 3'b100;
    localparam logic [2:0] C_ACTV = 3'b011;
    localparam logic [2:0] C_PREC = 3'b010;
    localparam logic [2:0] C_REFR = 3'b001;
    localparam logic [2:0] C_MODE = 3'b000;

    localparam logic [3:0] PINS_NOOP = 4'b0111;

    ddr3_cmd_timer dut (
        .clock       (clock),
        .reset       (reset),
        .cmd_valid_i (cmd_valid_i),
        .cmd_ready_o (cmd_ready_o),
        .cmd_i       (cmd_i),
        .bank_i      (bank_i),
        .addr_i      (addr_i),
        .rfc_o       (rfc_o),
        .ddr_cs_n_o  (ddr_cs_n_o),
        .ddr_ras_n_o (ddr_ras_n_o),
        .ddr_cas_n_o (ddr_cas_n_o),
        .ddr_we_n_o  (ddr_we_n_o),
        .ddr_ba_o    (ddr_ba_o),
        .ddr_a_o     (ddr_a_o),
        .dbg_state_o (dbg_state_o)
    );

    // ---------------- clock ----------------
    always #5 clock = ~clock;

    // ---------------- helpers ----------------
    task automatic check_val(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance to the next cycle; sample 1 time unit after the edge.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [3:0] pins();
        return {ddr_cs_n_o, ddr_ras_n_o, ddr_cas_n_o, ddr_we_n_o};
    endfunction

    task automatic drive(input logic v, input logic [2:0] c,
                         input logic [2:0] b, input logic [12:0] a);
        cmd_valid_i = v;
        cmd_i       = c;
        bank_i      = b;
        addr_i      = a;
    endtask

    // Issue one command from an idle timer and measure how many cycles
    // ready stays low afterwards (expected D-1).
    task automatic issue_and_time(input string tag, input logic [2:0] c,
                                  input int exp_low);
        logic [2:0]  b;
        logic [12:0] a;
        int          n;
        b = 3'($urandom_range(0, 7));
        a = 13'($urandom_range(0, 8191));
        drive(1'b1, c, b, a);
        check_val({tag, "_ready_before"}, 32'(cmd_ready_o), 32'd1);
        step();
        drive(1'b0, C_NOOP, 3'd0, 13'd0);
        check_val({tag, "_pins"}, 32'({pins(), ddr_ba_o, ddr_a_o}),
                  32'({1'b0, c, b, a}));
        n = 0;
        while (!cmd_ready_o && n < 1000) begin
            n++;
            step();
        end
        check_val({tag, "_busy_cycles"}, 32'(n), 32'(exp_low));
    endtask

    int rfc_seen;
    int n;

    // ---------------- stimulus ----------------
    initial begin
        reset = 1'b1;
        drive(1'b0, C_NOOP, 3'd0, 13'd0);
        step();
        step();
        check_val("ready_in_reset", 32'(cmd_ready_o), 32'd0);
        reset = 1'b0;
        #1;
        check_val("reset_ready", 32'(cmd_ready_o), 32'd1);
        check_val("reset_pins", 32'(pins()), 32'(PINS_NOOP));
        check_val("reset_ba_a", 32'({ddr_ba_o, ddr_a_o}), 32'd0);
        check_val("reset_rfc", 32'(rfc_o), 32'd0);

        // ACTV bank 2 row 0x123: one cycle on the pins, ready back in cycle 2.
        drive(1'b1, C_ACTV, 3'd2, 13'h123);
        step();
        drive(1'b0, C_NOOP, 3'd0, 13'd0);
        check_val("actv_c1_pins", 32'(pins()), 32'b0011);
        check_val("actv_c1_ba", 32'(ddr_ba_o), 32'd2);
        check_val("actv_c1_a", 32'(ddr_a_o), 32'h123);
        check_val("actv_c1_ready", 32'(cmd_ready_o), 32'd0);
        step();
        check_val("actv_c2_pins", 32'(pins()), 32'(PINS_NOOP));
        check_val("actv_c2_hold", 32'({ddr_ba_o, ddr_a_o}), 32'({3'd2, 13'h123}));
        check_val("actv_c2_ready", 32'(cmd_ready_o), 32'd1);

        // REFR: busy cycles 1-10, rfc in cycle 10 only; inputs toggled while
        // busy must be ignored. READ accepted in cycle 11 shows in cycle 12.
        drive(1'b1, C_REFR, 3'd5, 13'h400);
        step();
        check_val("refr_c1_pins", 32'({pins(), ddr_ba_o, ddr_a_o}),
                  32'({4'b0001, 3'd5, 13'h400}));
        for (int c = 1; c <= 10; c++) begin
            if (c > 1) begin
                check_val($sformatf("refr_c%0d_noop", c),
                          32'({pins(), ddr_ba_o, ddr_a_o}),
                          32'({PINS_NOOP, 3'd5, 13'h400}));
            end
            check_val($sformatf("refr_c%0d_ready", c), 32'(cmd_ready_o), 32'd0);
            check_val($sformatf("refr_c%0d_rfc", c), 32'(rfc_o), 32'(c == 10));
            drive(1'b1, C_ACTV, 3'($urandom_range(0, 7)), 13'($urandom_range(0, 8191)));
            step();
        end
        check_val("refr_c11_ready", 32'(cmd_ready_o), 32'd1);
        check_val("refr_c11_rfc", 32'(rfc_o), 32'd0);
        drive(1'b1, C_READ, 3'd1, 13'h045);
        step();
        drive(1'b0, C_NOOP, 3'd0, 13'd0);
        check_val("refr_read_c12", 32'({pins(), ddr_ba_o, ddr_a_o}),
                  32'({4'b0101, 3'd1, 13'h045}));
        n = 0;
        while (!cmd_ready_o && n < 100) begin
            n++;
            step();
        end
        check_val("read_busy_cycles", 32'(n), 32'd9);

        // WRIT then READ held valid: READ lands 12 cycles after WRIT.
        drive(1'b1, C_WRIT, 3'd3, 13'h010);
        step();
        check_val("writ_pins", 32'(pins()), 32'b0100);
        drive(1'b1, C_READ, 3'd4, 13'h020);
        n = 0;
        while (pins() != 4'b0101 && n < 100) begin
            n++;
            step();
        end
        drive(1'b0, C_NOOP, 3'd0, 13'd0);
        check_val("writ_to_read_gap", 32'(n), 32'd12);
        check_val("writ_read_addr", 32'({ddr_ba_o, ddr_a_o}), 32'({3'd4, 13'h020}));
        step();
        n = 0;
        while (!cmd_ready_o && n < 100) begin
            n++;
            step();
        end
        check_val("writ_read_ready", 32'(cmd_ready_o), 32'd1);

        // ZQCL in cycle 0, reset in cycle 100: NOOP and ready by cycle 102.
        rfc_seen = 0;
        drive(1'b1, C_ZQCL, 3'd6, 13'h1FF);
        step();
        drive(1'b0, C_NOOP, 3'd0, 13'd0);
        check_val("zqcl_pins", 32'(pins()), 32'b0110);
        for (int c = 1; c < 100; c++) begin
            if (rfc_o) rfc_seen++;
            if (cmd_ready_o) rfc_seen += 1000;
            step();
        end
        reset = 1'b1;
        #1;
        check_val("zqcl_ready_in_reset", 32'(cmd_ready_o), 32'd0);
        step();
        reset = 1'b0;
        if (rfc_o) rfc_seen++;
        step();
        check_val("zqcl_c102_pins", 32'(pins()), 32'(PINS_NOOP));
        check_val("zqcl_c102_ready", 32'(cmd_ready_o), 32'd1);
        check_val("zqcl_c102_ba_a", 32'({ddr_ba_o, ddr_a_o}), 32'd0);
        check_val("zqcl_no_rfc_busy_ok", 32'(rfc_seen), 32'd0);

        // NOOP valid for 5 cycles leaves the timer idle and pins unchanged.
        for (int c = 0; c < 5; c++) begin
            drive(1'b1, C_NOOP, 3'd7, 13'h1ABC);
            check_val($sformatf("noop%0d_ready", c), 32'(cmd_ready_o), 32'd1);
            step();
            check_val($sformatf("noop%0d_pins", c),
                      32'({pins(), ddr_ba_o, ddr_a_o}), 32'({PINS_NOOP, 16'd0}));
        end
        check_val("noop_ready_after", 32'(cmd_ready_o), 32'd1);
        drive(1'b1, C_PREC, 3'd7, 13'h0400);
        step();
        drive(1'b0, C_NOOP, 3'd0, 13'd0);
        check_val("prec_pins", 32'(pins()), 32'b0010);
        check_val("prec_a10", 32'(ddr_a_o[10]), 32'd1);
        check_val("prec_ready_low", 32'(cmd_ready_o), 32'd0);
        step();
        check_val("prec_ready_high", 32'(cmd_ready_o), 32'd1);

        // Remaining delay table entries.
        issue_and_time("mode", C_MODE, 11);
        issue_and_time("read", C_READ, 9);
        issue_and_time("writ", C_WRIT, 11);
        issue_and_time("prec", C_PREC, 1);
        issue_and_time("refr", C_REFR, 10);
        issue_and_time("zqcl", C_ZQCL, 511);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
